// File: rtl/mkgauss_pkg.sv
// Shared constants, types and helpers for the Falcon small-polynomial sampler.
// Optional statistics port is enabled with `define MKGAUSS_STATS_EN.
package mkgauss_pkg;

   localparam int unsigned ACC_W       = 16;
   localparam int unsigned FALCON_LOGN = 10;
   localparam int unsigned CDT_LEN     = 27;
   localparam int unsigned SAMPLE_W    = 6;

   // Reverse cumulative table for gauss_1024_12289 (63-bit magnitudes)
   localparam logic [62:0] CDT [CDT_LEN] = '{
      63'd1283868770400643928, 63'd6416574995475331444, 63'd4078260278032692663,
      63'd2353523259288686585, 63'd1227179971273316331, 63'd575931623374121527,
      63'd242543240509105209,  63'd91437049221049666,   63'd30799446349977173,
      63'd9255276791179340,    63'd2478152334826140,    63'd590642893610164,
      63'd125206034929641,     63'd23590435911403,      63'd3948334035941,
      63'd586753615614,        63'd77391054539,         63'd9056793210,
      63'd940121950,           63'd86539696,            63'd7062824,
      63'd510971,              63'd32764,               63'd1862,
      63'd94,                  63'd4,                   63'd0
   };

   localparam int unsigned MAX_FG_BITS [FALCON_LOGN + 1] = '{0, 8, 8, 8, 8, 8, 7, 7, 6, 6, 5};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      CHECK = 2'd2,
      OUT   = 2'd3
   } state_t;

   // Symmetric acceptance bound 2^(MAX_FG_BITS[logn]-1); 0 for unsupported logn
   function automatic logic [ACC_W-1:0] fg_lim(input logic [3:0] logn);
      logic [ACC_W-1:0] r;
      r = '0;
      if (logn >= 4'd1 && 32'(logn) <= FALCON_LOGN)
         r = ACC_W'(32'd1 << (MAX_FG_BITS[logn] - 32'd1));
      return r;
   endfunction

endpackage

// File: rtl/mkgauss_cdt_lane.sv
// Combinational sub-sampler: one 128-bit RNG word -> signed CDT sample in [-26, 26].
module mkgauss_cdt_lane
   import mkgauss_pkg::*;
(
   input  logic [127:0]               word,
   output logic signed [SAMPLE_W-1:0] sample
);

   logic [63:0] w0;
   logic [62:0] w1_mag;
   logic [4:0]  mag;
   logic        unused_w1_sign;

   assign w0             = word[63:0];
   assign w1_mag         = word[126:64];
   assign unused_w1_sign = word[127];

   // Smallest k >= 1 with w1 >= CDT[k], zeroed when w0 falls below CDT[0]
   always_comb begin
      mag = '0;
      for (int k = CDT_LEN - 1; k >= 1; k--) begin
         if (w1_mag >= CDT[k]) mag = 5'(k);
      end
      if (w0[62:0] < CDT[0]) mag = '0;
      sample = w0[63] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
   end

endmodule

// File: rtl/poly_small_mkgauss_stream.sv
// Streaming Falcon f/g sampler: sums g CDT sub-samples per coefficient,
// applies range and last-coefficient parity rejection, emits over valid/ready.
// Optional rej_cnt output is enabled with `define MKGAUSS_STATS_EN.
module poly_small_mkgauss_stream
   import mkgauss_pkg::*;
#(
   parameter int unsigned LOGN_MAX = 10,
   parameter int unsigned COEF_W   = 8
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [3:0]               logn,
   output logic                     busy,
   output logic                     done,
   input  logic                     rng_valid,
   input  logic [127:0]             rng,
   output logic                     rng_extract,
   output logic                     coef_valid,
   input  logic                     coef_ready,
   output logic signed [COEF_W-1:0] coef,
   output logic [LOGN_MAX-1:0]      coef_idx,
   output logic                     coef_last
`ifdef MKGAUSS_STATS_EN
   ,
   output logic [15:0]              rej_cnt
`endif
);

   localparam int unsigned IDX_W  = LOGN_MAX;
   localparam int unsigned WCNT_W = FALCON_LOGN;

   state_t                     state, state_nxt;
   logic signed [SAMPLE_W-1:0] sample;
   logic signed [ACC_W-1:0]    acc, acc_sum, lim;
   logic [IDX_W-1:0]           n_m1;
   logic [WCNT_W-1:0]          g_m1, wcnt;
   logic                       mod2;
   logic                       start_ok, consume, last_word, reject, handshake;

   mkgauss_cdt_lane u_lane (
      .word   (rng),
      .sample (sample)
   );

   assign start_ok  = start && (logn >= 4'd1) && (32'(logn) <= LOGN_MAX);
   assign consume   = (state == ACCUM) && rng_valid;
   assign last_word = (wcnt == g_m1);
   assign acc_sum   = acc + ACC_W'(sample);
   assign handshake = (state == OUT) && coef_ready;
   assign reject    = (acc < -lim) || (acc >= lim) || (coef_last && ((mod2 ^ acc[0]) == 1'b0));

   // Word consumption is combinational so the source can advance next cycle
   assign rng_extract = consume;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok) state_nxt = ACCUM;
         ACCUM:   if (consume && last_word) state_nxt = CHECK;
         CHECK:   state_nxt = reject ? ACCUM : OUT;
         OUT:     if (coef_ready) state_nxt = coef_last ? IDLE : ACCUM;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: accumulator, index, derived parameters and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         coef_valid <= 1'b0;
         coef       <= '0;
         coef_idx   <= '0;
         coef_last  <= 1'b0;
         acc        <= '0;
         mod2       <= 1'b0;
         wcnt       <= '0;
         n_m1       <= '0;
         g_m1       <= '0;
         lim        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  busy      <= 1'b1;
                  n_m1      <= IDX_W'((32'd1 << logn) - 32'd1);
                  g_m1      <= WCNT_W'((32'd1 << (FALCON_LOGN - 32'(logn))) - 32'd1);
                  lim       <= $signed(fg_lim(logn));
                  coef_idx  <= '0;
                  coef_last <= 1'b0;
                  acc       <= '0;
                  wcnt      <= '0;
                  mod2      <= 1'b0;
               end
            end
            ACCUM: begin
               if (consume) begin
                  acc  <= acc_sum;
                  wcnt <= last_word ? '0 : WCNT_W'(wcnt + WCNT_W'(1));
               end
            end
            CHECK: begin
               if (reject) begin
                  acc <= '0;
               end else begin
                  coef       <= COEF_W'(acc);
                  coef_valid <= 1'b1;
                  if (!coef_last) mod2 <= mod2 ^ acc[0];
               end
            end
            OUT: begin
               if (coef_ready) begin
                  coef_valid <= 1'b0;
                  acc        <= '0;
                  if (coef_last) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end else begin
                     coef_idx  <= IDX_W'(coef_idx + IDX_W'(1));
                     coef_last <= (IDX_W'(coef_idx + IDX_W'(1)) == n_m1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MKGAUSS_STATS_EN
   // Saturating count of CHECK rejections within the current polynomial
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  rej_cnt <= '0;
      else if (state == IDLE && start_ok)       rej_cnt <= '0;
      else if (state == CHECK && reject && rej_cnt != 16'hFFFF)
                                                rej_cnt <= rej_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_poly_small_mkgauss_stream.sv
// Directed bench for poly_small_mkgauss_stream: sign/magnitude, parity,
// range rejection, backpressure, RNG stall, reset and ignored starts.
module tb_poly_small_mkgauss_stream;

   logic               clk = 1'b0;
   logic               rst, start, rng_valid, rng_extract, busy, done;
   logic               coef_valid, coef_ready, coef_last;
   logic [3:0]         logn;
   logic [127:0]       rng;
   logic signed [7:0]  coef;
   logic [9:0]         coef_idx;
`ifdef MKGAUSS_STATS_EN
   logic [15:0]        rej_cnt;
`endif

   poly_small_mkgauss_stream #(.LOGN_MAX(10), .COEF_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .logn        (logn),
      .busy        (busy),
      .done        (done),
      .rng_valid   (rng_valid),
      .rng         (rng),
      .rng_extract (rng_extract),
      .coef_valid  (coef_valid),
      .coef_ready  (coef_ready),
      .coef        (coef),
      .coef_idx    (coef_idx),
      .coef_last   (coef_last)
`ifdef MKGAUSS_STATS_EN
      ,
      .rej_cnt     (rej_cnt)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [127:0] W_P1  = {64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
   localparam logic [127:0] W_M1  = {64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
   localparam logic [127:0] W_Z   = 128'd0;
   localparam logic [127:0] W_V20 = {1'b0, 63'd7062824, 64'h7FFF_FFFF_FFFF_FFFF};

   int           n_tests = 0;
   int           n_fail  = 0;
   int           ext_cnt = 0;
   int           cyc     = 0;
   logic [127:0] q[$];

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // RNG source: presents queue head, advances the cycle after an extract
   initial begin
      logic e;
      rng_valid = 1'b0;
      rng       = '0;
      forever begin
         @(negedge clk);
         e = rng_extract;
         if (e) ext_cnt++;
         @(posedge clk);
         #1;
         if (e && q.size() > 0) void'(q.pop_front());
         rng_valid = (q.size() > 0);
         rng       = (q.size() > 0) ? q[0] : '0;
      end
   end

   task automatic do_start(input logic [3:0] l);
      @(negedge clk);
      start = 1'b1;
      logn  = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int maxc, output bit ok);
      int k;
      k = 0;
      @(negedge clk);
      while (!coef_valid && k < maxc) begin
         @(negedge clk);
         k++;
      end
      ok = coef_valid;
      if (!ok) check(tag, 64'(coef_valid), 64'd1);
   endtask

   initial begin
      bit ok;
      int bad, e0, t0, t1;
      logic signed [63:0] expv;

      rst = 1'b1; start = 1'b0; logn = 4'd0; coef_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_outs", 64'({busy, done, coef_valid, coef_last, rng_extract, coef, coef_idx}), 64'd0);
      rst = 1'b0;

      // Sign/magnitude: +1,+1,-1 pattern, even-valued last coefficient
      for (int i = 0; i < 1023; i++) q.push_back((i % 3 == 2) ? W_M1 : W_P1);
      q.push_back(W_Z);
      e0 = ext_cnt; bad = 0; t0 = 0; t1 = 0;
      do_start(4'd10);
      check("sm_busy", 64'(busy), 64'd1);
      for (int i = 0; i < 1024; i++) begin
         wait_valid("sm_timeout", 20, ok);
         if (!ok) break;
         if (i == 0) t0 = cyc;
         t1 = cyc;
         expv = (i == 1023) ? 64'sd0 : ((i % 3 == 2) ? -64'sd1 : 64'sd1);
         if (64'(coef) !== expv || 32'(coef_idx) != i || coef_last !== (i == 1023)) bad++;
      end
      check("sm_bad_coefs", 64'(bad), 64'd0);
      check("sm_period", 64'(t1 - t0), 64'd3069);
      @(negedge clk);
      check("sm_done", 64'(done), 64'd1);
      check("sm_busy_clr", 64'(busy), 64'd0);
      check("sm_extracts", 64'(ext_cnt - e0), 64'd1024);
`ifdef MKGAUSS_STATS_EN
      check("sm_rej_cnt", 64'(rej_cnt), 64'd0);
`endif
      @(negedge clk);
      check("sm_done_pulse", 64'(done), 64'd0);

      // Parity: zeros everywhere, last index needs an odd sum
      for (int i = 0; i < 1026; i++) q.push_back(W_Z);
      q.push_back(W_P1);
      e0 = ext_cnt; bad = 0;
      do_start(4'd10);
      for (int i = 0; i < 1024; i++) begin
         wait_valid("par_timeout", 20, ok);
         if (!ok) break;
         if (i < 1023 && (coef !== 8'sd0 || 32'(coef_idx) != i || coef_last)) bad++;
      end
      check("par_bad_coefs", 64'(bad), 64'd0);
      check("par_last_coef", 64'(coef), 64'sd1);
      check("par_last_idx", 64'(coef_idx), 64'd1023);
      check("par_last_flag", 64'(coef_last), 64'd1);
      @(negedge clk);
      check("par_done", 64'(done), 64'd1);
      check("par_extracts", 64'(ext_cnt - e0), 64'd1027);
`ifdef MKGAUSS_STATS_EN
      check("par_rej_cnt", 64'(rej_cnt), 64'd3);
`endif

      // Range reject (logn=8, lim=32), start while busy, backpressure
      coef_ready = 1'b0;
      for (int i = 0; i < 4; i++) q.push_back(W_V20);
      for (int i = 0; i < 4; i++) q.push_back(W_P1);
      e0 = ext_cnt;
      do_start(4'd8);
      do_start(4'd10);
      wait_valid("rg_timeout", 40, ok);
      check("rg_coef", 64'(coef), 64'sd4);
      check("rg_idx", 64'(coef_idx), 64'd0);
      check("rg_extracts", 64'(ext_cnt - e0), 64'd8);
`ifdef MKGAUSS_STATS_EN
      check("rg_rej_cnt", 64'(rej_cnt), 64'd1);
`endif
      q.push_back(W_P1);
      q.push_back(W_P1);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (!coef_valid || coef !== 8'sd4 || coef_idx !== 10'd0 || rng_extract) bad++;
      end
      check("bp_stable", 64'(bad), 64'd0);
      check("bp_no_extract", 64'(ext_cnt - e0), 64'd8);

      // RNG stall mid-accumulation, then the remaining two words
      coef_ready = 1'b1;
      repeat (8) @(negedge clk);
      check("stall_no_valid", 64'(coef_valid), 64'd0);
      check("stall_busy", 64'(busy), 64'd1);
      q.push_back(W_P1);
      q.push_back(W_P1);
      wait_valid("stall_timeout", 20, ok);
      check("stall_coef", 64'(coef), 64'sd4);
      check("stall_idx", 64'(coef_idx), 64'd1);

      // Reset mid-ACCUM on index 2
      q.push_back(W_P1);
      repeat (4) @(negedge clk);
      check("pre_rst_idx", 64'(coef_idx), 64'd2);
      rst = 1'b1;
      #1;
      check("rst_mid_outs", 64'({busy, done, coef_valid, coef_last, rng_extract, coef, coef_idx}), 64'd0);
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Out-of-range logn must be ignored
      for (int i = 0; i < 4; i++) q.push_back(W_P1);
      e0 = ext_cnt;
      do_start(4'd0);
      repeat (3) @(negedge clk);
      check("logn0_busy", 64'(busy), 64'd0);
      do_start(4'd11);
      repeat (3) @(negedge clk);
      check("logn11_busy", 64'(busy), 64'd0);
      check("bad_logn_extracts", 64'(ext_cnt - e0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
